// File: rtl/predecode_align_stage_pkg.sv
// rtl/predecode_align_stage_pkg.sv - shared frontend predecode types, opcodes and geometry helpers
package predecode_align_stage_pkg;

  // Targets are computed at full 64-bit width and truncated to VADDR_SIZE by the user.
  localparam int PD_PC_W = 64;

  typedef struct packed {
    logic               rvc;
    logic               direct;
    logic               cond;
    logic               indirect;
    logic [PD_PC_W-1:0] target;
  } pd_inst_info_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] RVC_Q1  = 2'b01;
  localparam logic [1:0] RVC_Q2  = 2'b10;
  localparam logic [1:0] RVI_LOW = 2'b11;

  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_JR   = 3'b100;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;

  function automatic int calc_hw(input int fetch_bytes);
    return fetch_bytes / 2;
  endfunction

  function automatic int calc_hw_w(input int fetch_bytes);
    return $clog2(fetch_bytes / 2);
  endfunction

endpackage

// File: rtl/predecode_align_stage_if.sv
// rtl/predecode_align_stage_if.sv - fetch-block in / compacted-block and redirect out bundle
interface predecode_align_stage_if
  import predecode_align_stage_pkg::*;
#(
  parameter int FETCH_BYTES = 32,
  parameter int VADDR_SIZE  = 39,
  parameter int FSQ_WIDTH   = 4
);
  localparam int HW   = calc_hw(FETCH_BYTES);
  localparam int HW_W = calc_hw_w(FETCH_BYTES);

  logic                     in_valid;
  logic                     in_ready;
  logic [FETCH_BYTES*8-1:0] in_data;
  logic [HW-1:0]            in_hw_mask;
  logic [VADDR_SIZE-1:0]    in_start_addr;
  logic [FSQ_WIDTH-1:0]     in_fsq_idx;
  logic                     in_taken;
  logic [HW_W-1:0]          in_taken_hw;
  logic [VADDR_SIZE-1:0]    in_target;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [HW_W:0]            out_num;
  logic [HW*32-1:0]         out_inst;
  logic [HW*(HW_W+1)-1:0]   out_offset;
  logic [HW-1:0]            out_rvc;
  logic [FSQ_WIDTH-1:0]     out_fsq_idx;
  logic                     redir_valid;
  logic [FSQ_WIDTH-1:0]     redir_fsq_idx;
  logic                     redir_taken;
  logic [VADDR_SIZE-1:0]    redir_target;
  logic [HW_W-1:0]          redir_hw;

  modport master (
    output in_valid, in_data, in_hw_mask, in_start_addr, in_fsq_idx, in_taken,
           in_taken_hw, in_target, flush, out_ready,
    input  in_ready, out_valid, out_num, out_inst, out_offset, out_rvc, out_fsq_idx,
           redir_valid, redir_fsq_idx, redir_taken, redir_target, redir_hw
  );

  modport slave (
    input  in_valid, in_data, in_hw_mask, in_start_addr, in_fsq_idx, in_taken,
           in_taken_hw, in_target, flush, out_ready,
    output in_ready, out_valid, out_num, out_inst, out_offset, out_rvc, out_fsq_idx,
           redir_valid, redir_fsq_idx, redir_taken, redir_target, redir_hw
  );

endinterface

// File: rtl/predecode_align_stage_pd_inst_decoder.sv
// rtl/predecode_align_stage_pd_inst_decoder.sv - classifies one 32-bit window and computes its jump target
module pd_inst_decoder
  import predecode_align_stage_pkg::*;
#(
  parameter bit RVC_EN = 1'b1
) (
  input  logic [31:0]        inst,
  input  logic [PD_PC_W-1:0] pc,
  output pd_inst_info_t      info
);

  logic               is_rvc;
  logic [2:0]         c_f3;
  logic [PD_PC_W-1:0] imm_j;
  logic [PD_PC_W-1:0] imm_cj;

  always_comb begin
    is_rvc = RVC_EN && (inst[1:0] != RVI_LOW);
    c_f3   = inst[15:13];
    imm_j  = {{(PD_PC_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_cj = {{(PD_PC_W-11){inst[12]}}, inst[8], inst[10:9], inst[6], inst[7], inst[2],
              inst[11], inst[5:3], 1'b0};
    info     = '0;
    info.rvc = is_rvc;
    if (is_rvc) begin
      info.direct   = (inst[1:0] == RVC_Q1) && ((c_f3 == C_F3_J) || (c_f3 == C_F3_JAL));
      info.cond     = (inst[1:0] == RVC_Q1) && ((c_f3 == C_F3_BEQZ) || (c_f3 == C_F3_BNEZ));
      // c.jr / c.jalr: rs2 == 0 and rs1 != 0; inst[12] only selects link.
      info.indirect = (inst[1:0] == RVC_Q2) && (c_f3 == C_F3_JR) &&
                      (inst[6:2] == 5'd0) && (inst[11:7] != 5'd0);
      info.target   = pc + imm_cj;
    end else begin
      info.direct   = (inst[6:0] == OPC_JAL);
      info.cond     = (inst[6:0] == OPC_BRANCH);
      info.indirect = (inst[6:0] == OPC_JALR);
      info.target   = pc + imm_j;
    end
  end

endmodule

// File: rtl/predecode_align_stage.sv
// rtl/predecode_align_stage.sv - splits fetch blocks into instructions, carries split RVI, checks BPU prediction
module predecode_align_stage
  import predecode_align_stage_pkg::*;
#(
  parameter int FETCH_BYTES = 32,
  parameter int VADDR_SIZE  = 39,
  parameter int FSQ_WIDTH   = 4,
  parameter bit RVC_EN      = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  predecode_align_stage_if.slave bus
);

  localparam int HW    = calc_hw(FETCH_BYTES);
  localparam int HW_W  = calc_hw_w(FETCH_BYTES);
  localparam int OFF_W = HW_W + 1;
  typedef logic [VADDR_SIZE-1:0] vaddr_t;

  logic                   out_valid_q, out_valid_d;
  logic [OFF_W-1:0]       out_num_q, out_num_d;
  logic [HW*32-1:0]       out_inst_q, out_inst_d;
  logic [HW*OFF_W-1:0]    out_offset_q, out_offset_d;
  logic [HW-1:0]          out_rvc_q, out_rvc_d;
  logic [FSQ_WIDTH-1:0]   out_fsq_idx_q, out_fsq_idx_d;
  logic                   redir_valid_q, redir_valid_d;
  logic                   redir_taken_q, redir_taken_d;
  vaddr_t                 redir_target_q, redir_target_d;
  logic [HW_W-1:0]        redir_hw_q, redir_hw_d;
  logic                   carry_valid_q, carry_valid_d;
  logic [15:0]            carry_hw_q, carry_hw_d;
  vaddr_t                 carry_pc_q, carry_pc_d;
  logic                   drop_q, drop_d;

  logic [FETCH_BYTES*8+15:0] data_x;
  logic [HW:0]               mask_x;
  logic                      cont;
  logic [31:0]               win [HW];
  logic [PD_PC_W-1:0]        win_pc [HW];
  pd_inst_info_t             info [HW];

  logic                   inst_ok [HW];
  logic [HW_W-1:0]        inst_end [HW];
  logic                   cand_valid;
  logic [HW_W-1:0]        cand_idx;
  logic [15:0]            cand_hw;
  int                     walk_nxt;

  logic                   j_found, p_found, p_cf;
  logic [HW_W-1:0]        j_end, trunc_hw;
  logic [PD_PC_W-1:0]     j_tgt, p_tgt;
  logic                   p_direct;
  logic                   chk1, chk2, chk3, redir, carry_new;
  vaddr_t                 redir_tgt_c;

  logic [HW*32-1:0]       pk_inst;
  logic [HW*OFF_W-1:0]    pk_off;
  logic [HW-1:0]          pk_rvc;
  int                     pk_cnt;

  logic                   in_ready, acc, drop_now;

  always_comb begin
    data_x = {16'h0, bus.in_data};
    mask_x = {1'b0, bus.in_hw_mask};
    cont   = carry_valid_q && bus.in_hw_mask[0] && (bus.in_start_addr == carry_pc_q + vaddr_t'(2));
    for (int i = 0; i < HW; i++) begin
      win[i]    = data_x[16*i +: 32];
      win_pc[i] = PD_PC_W'(bus.in_start_addr) + PD_PC_W'(2 * i);
    end
    // A continuation decodes from the saved low halfword at the saved pc.
    if (cont) begin
      win[0]    = {data_x[15:0], carry_hw_q};
      win_pc[0] = PD_PC_W'(carry_pc_q);
    end
  end

  for (genvar g = 0; g < HW; g++) begin : g_dec
    pd_inst_decoder #(.RVC_EN(RVC_EN)) u_dec (
      .inst (win[g]),
      .pc   (win_pc[g]),
      .info (info[g])
    );
  end

  always_comb begin
    walk_nxt   = cont ? 1 : 0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    cand_hw    = '0;
    for (int i = 0; i < HW; i++) begin
      inst_ok[i]  = 1'b0;
      inst_end[i] = HW_W'(i);
      if (i == 0 && cont) begin
        inst_ok[i] = 1'b1;
      end else if (i == walk_nxt && mask_x[i]) begin
        if (info[i].rvc) begin
          inst_ok[i] = 1'b1;
          walk_nxt   = i + 1;
        end else if (mask_x[i+1]) begin
          inst_ok[i]  = 1'b1;
          inst_end[i] = HW_W'(i + 1);
          walk_nxt    = i + 2;
        end else begin
          cand_valid = 1'b1;
          cand_idx   = HW_W'(i);
          cand_hw    = data_x[16*i +: 16];
        end
      end
    end
  end

  always_comb begin
    j_found  = 1'b0;
    j_end    = '0;
    j_tgt    = '0;
    p_found  = 1'b0;
    p_cf     = 1'b0;
    p_direct = 1'b0;
    p_tgt    = '0;
    for (int i = 0; i < HW; i++) begin
      if (inst_ok[i]) begin
        if (info[i].direct && !j_found) begin
          j_found = 1'b1;
          j_end   = inst_end[i];
          j_tgt   = info[i].target;
        end
        if (inst_end[i] == bus.in_taken_hw) begin
          p_found  = 1'b1;
          p_cf     = info[i].direct | info[i].cond | info[i].indirect;
          p_direct = info[i].direct;
          p_tgt    = info[i].target;
        end
      end
    end
    chk1  = j_found && (!bus.in_taken || (j_end < bus.in_taken_hw));
    chk2  = !chk1 && bus.in_taken && !(p_found && p_cf);
    chk3  = !chk1 && !chk2 && bus.in_taken && p_direct && (bus.in_target != vaddr_t'(p_tgt));
    redir = chk1 | chk2 | chk3;
    trunc_hw = chk1 ? j_end : (bus.in_taken ? bus.in_taken_hw : HW_W'(HW - 1));
    if (chk1)
      redir_tgt_c = vaddr_t'(j_tgt);
    else if (chk2)
      redir_tgt_c = bus.in_start_addr + vaddr_t'({bus.in_taken_hw, 1'b0}) + vaddr_t'(2);
    else
      redir_tgt_c = vaddr_t'(p_tgt);
    carry_new = cand_valid && !redir && !(bus.in_taken && (bus.in_taken_hw < cand_idx));
  end

  always_comb begin
    pk_inst = '0;
    pk_off  = '0;
    pk_rvc  = '0;
    pk_cnt  = 0;
    for (int i = 0; i < HW; i++) begin
      if (inst_ok[i] && (inst_end[i] <= trunc_hw)) begin
        pk_inst[pk_cnt*32 +: 32]     = info[i].rvc ? {16'h0, win[i][15:0]} : win[i];
        pk_off[pk_cnt*OFF_W +: OFF_W] = (i == 0 && cont) ? OFF_W'(HW) : OFF_W'(i);
        pk_rvc[pk_cnt]               = info[i].rvc;
        pk_cnt                       = pk_cnt + 1;
      end
    end
  end

  always_comb begin
    in_ready = ~out_valid_q | bus.out_ready;
    acc      = bus.in_valid & in_ready;
    // The block leaving with a redirect poisons everything accepted from this edge on.
    drop_now = drop_q | (out_valid_q & bus.out_ready & redir_valid_q);

    out_valid_d    = out_valid_q;
    out_num_d      = out_num_q;
    out_inst_d     = out_inst_q;
    out_offset_d   = out_offset_q;
    out_rvc_d      = out_rvc_q;
    out_fsq_idx_d  = out_fsq_idx_q;
    redir_valid_d  = redir_valid_q;
    redir_taken_d  = redir_taken_q;
    redir_target_d = redir_target_q;
    redir_hw_d     = redir_hw_q;
    carry_valid_d  = carry_valid_q;
    carry_hw_d     = carry_hw_q;
    carry_pc_d     = carry_pc_q;
    drop_d         = drop_now;

    if (bus.flush) begin
      out_valid_d   = 1'b0;
      redir_valid_d = 1'b0;
      carry_valid_d = 1'b0;
      drop_d        = 1'b0;
    end else if (acc && !drop_now) begin
      out_valid_d    = 1'b1;
      out_num_d      = OFF_W'(pk_cnt);
      out_inst_d     = pk_inst;
      out_offset_d   = pk_off;
      out_rvc_d      = pk_rvc;
      out_fsq_idx_d  = bus.in_fsq_idx;
      redir_valid_d  = redir;
      redir_taken_d  = chk1 | chk3;
      redir_target_d = redir_tgt_c;
      redir_hw_d     = chk1 ? j_end : bus.in_taken_hw;
      carry_valid_d  = carry_new;
      if (carry_new) begin
        carry_hw_d = cand_hw;
        carry_pc_d = bus.in_start_addr + vaddr_t'({cand_idx, 1'b0});
      end
    end else if (bus.out_ready) begin
      out_valid_d   = 1'b0;
      redir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_num_q      <= '0;
      out_inst_q     <= '0;
      out_offset_q   <= '0;
      out_rvc_q      <= '0;
      out_fsq_idx_q  <= '0;
      redir_valid_q  <= 1'b0;
      redir_taken_q  <= 1'b0;
      redir_target_q <= '0;
      redir_hw_q     <= '0;
      carry_valid_q  <= 1'b0;
      carry_hw_q     <= '0;
      carry_pc_q     <= '0;
      drop_q         <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_num_q      <= out_num_d;
      out_inst_q     <= out_inst_d;
      out_offset_q   <= out_offset_d;
      out_rvc_q      <= out_rvc_d;
      out_fsq_idx_q  <= out_fsq_idx_d;
      redir_valid_q  <= redir_valid_d;
      redir_taken_q  <= redir_taken_d;
      redir_target_q <= redir_target_d;
      redir_hw_q     <= redir_hw_d;
      carry_valid_q  <= carry_valid_d;
      carry_hw_q     <= carry_hw_d;
      carry_pc_q     <= carry_pc_d;
      drop_q         <= drop_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_num       = out_num_q;
  assign bus.out_inst      = out_inst_q;
  assign bus.out_offset    = out_offset_q;
  assign bus.out_rvc       = out_rvc_q;
  assign bus.out_fsq_idx   = out_fsq_idx_q;
  assign bus.redir_valid   = redir_valid_q;
  assign bus.redir_fsq_idx = out_fsq_idx_q;
  assign bus.redir_taken   = redir_taken_q;
  assign bus.redir_target  = redir_target_q;
  assign bus.redir_hw      = redir_hw_q;

endmodule

// File: tb/tb_predecode_align_stage.sv
// tb/tb_predecode_align_stage.sv - directed-vector bench for predecode_align_stage with 16-byte blocks
module tb_predecode_align_stage;

  localparam logic [15:0] C_ADDI = 16'h0085;
  localparam logic [15:0] C_J60  = 16'hA835;
  localparam logic [31:0] ADD    = 32'h003100B3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  predecode_align_stage_if #(.FETCH_BYTES(16), .VADDR_SIZE(39), .FSQ_WIDTH(4)) bus ();

  predecode_align_stage #(.FETCH_BYTES(16), .VADDR_SIZE(39), .FSQ_WIDTH(4), .RVC_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] blk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 8; i++) blk[16*i +: 16] = v;
  endtask

  task automatic put(input int i, input logic [15:0] v);
    blk[16*i +: 16] = v;
  endtask

  task automatic drive(input logic [38:0] addr, input logic [7:0] mask, input logic tk,
                       input logic [2:0] tk_hw, input logic [38:0] tgt, input logic [3:0] fsq);
    bus.in_data       = blk;
    bus.in_hw_mask    = mask;
    bus.in_start_addr = addr;
    bus.in_taken      = tk;
    bus.in_taken_hw   = tk_hw;
    bus.in_target     = tgt;
    bus.in_fsq_idx    = fsq;
    bus.in_valid      = 1'b1;
  endtask

  // Presents one block, waits for acceptance, returns #1 after the accepting edge.
  task automatic send(input logic [38:0] addr, input logic [7:0] mask, input logic tk,
                      input logic [2:0] tk_hw, input logic [38:0] tgt, input logic [3:0] fsq);
    int n;
    @(negedge clk);
    drive(addr, mask, tk, tk_hw, tgt, fsq);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  function automatic logic [31:0] slot_inst(input int k);
    return bus.out_inst[32*k +: 32];
  endfunction

  function automatic logic [3:0] slot_off(input int k);
    return bus.out_offset[4*k +: 4];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_hw_mask = '0; bus.in_start_addr = '0;
    bus.in_fsq_idx = '0; bus.in_taken = 1'b0; bus.in_taken_hw = '0; bus.in_target = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_redir_valid", 64'(bus.redir_valid), 64'd0);
    check_val("rst_out_num", 64'(bus.out_num), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Eight c.addi, no prediction.
    fill(C_ADDI);
    send(39'h1000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd1);
    check_val("t1_valid", 64'(bus.out_valid), 64'd1);
    check_val("t1_num", 64'(bus.out_num), 64'd8);
    check_val("t1_redir", 64'(bus.redir_valid), 64'd0);
    check_val("t1_fsq", 64'(bus.out_fsq_idx), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("t1_off%0d", k), 64'(slot_off(k)), 64'(k));
      check_val($sformatf("t1_inst%0d", k), 64'(slot_inst(k)), 64'h85);
    end
    check_val("t1_rvc", 64'(bus.out_rvc), 64'hFF);

    // RVI split across two consecutive blocks.
    fill(C_ADDI); put(7, ADD[15:0]);
    send(39'h1000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd2);
    check_val("t2a_num", 64'(bus.out_num), 64'd7);
    fill(C_ADDI); put(0, ADD[31:16]);
    send(39'h1010, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd3);
    check_val("t2b_num", 64'(bus.out_num), 64'd8);
    check_val("t2b_off0", 64'(slot_off(0)), 64'd8);
    check_val("t2b_inst0", 64'(slot_inst(0)), 64'(ADD));
    check_val("t2b_rvc0", 64'(bus.out_rvc[0]), 64'd0);
    check_val("t2b_off1", 64'(slot_off(1)), 64'd1);
    check_val("t2b_redir", 64'(bus.redir_valid), 64'd0);
    fill(C_ADDI);
    send(39'h1010, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd3);
    check_val("t2c_off0", 64'(slot_off(0)), 64'd0);
    check_val("t2c_num", 64'(bus.out_num), 64'd8);

    // Carry held, next block elsewhere: carry dropped.
    fill(C_ADDI); put(7, ADD[15:0]);
    send(39'h1000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd4);
    fill(C_ADDI);
    send(39'h2000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd5);
    check_val("t3_num", 64'(bus.out_num), 64'd8);
    check_val("t3_off0", 64'(slot_off(0)), 64'd0);
    check_val("t3_inst0", 64'(slot_inst(0)), 64'h85);

    // c.j at hw2, unpredicted: redirect then drop until flush.
    fill(C_ADDI); put(2, C_J60);
    send(39'h1000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd6);
    check_val("t4_num", 64'(bus.out_num), 64'd3);
    check_val("t4_inst2", 64'(slot_inst(2)), 64'hA835);
    check_val("t4_redir", 64'(bus.redir_valid), 64'd1);
    check_val("t4_rtaken", 64'(bus.redir_taken), 64'd1);
    check_val("t4_rtgt", 64'(bus.redir_target), 64'h1040);
    check_val("t4_rhw", 64'(bus.redir_hw), 64'd2);
    check_val("t4_rfsq", 64'(bus.redir_fsq_idx), 64'd6);
    fill(C_ADDI);
    send(39'h1040, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd7);
    check_val("t4_drop1", 64'(bus.out_valid), 64'd0);
    send(39'h1050, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd7);
    check_val("t4_drop2", 64'(bus.out_valid), 64'd0);
    do_flush();
    send(39'h1040, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd8);
    check_val("t4_post_valid", 64'(bus.out_valid), 64'd1);
    check_val("t4_post_num", 64'(bus.out_num), 64'd8);

    // Predicted taken at hw5 on a non-control instruction.
    fill(C_ADDI);
    send(39'h1000, 8'hFF, 1'b1, 3'd5, 39'h5000, 4'd9);
    check_val("t5_num", 64'(bus.out_num), 64'd6);
    check_val("t5_redir", 64'(bus.redir_valid), 64'd1);
    check_val("t5_rtaken", 64'(bus.redir_taken), 64'd0);
    check_val("t5_rtgt", 64'(bus.redir_target), 64'h100C);
    check_val("t5_rhw", 64'(bus.redir_hw), 64'd5);
    do_flush();

    // Predicted c.j with right and wrong targets.
    fill(C_ADDI); put(2, C_J60);
    send(39'h1000, 8'hFF, 1'b1, 3'd2, 39'h1040, 4'd10);
    check_val("t6a_num", 64'(bus.out_num), 64'd3);
    check_val("t6a_redir", 64'(bus.redir_valid), 64'd0);
    send(39'h1000, 8'hFF, 1'b1, 3'd2, 39'h2000, 4'd11);
    check_val("t6b_redir", 64'(bus.redir_valid), 64'd1);
    check_val("t6b_rtaken", 64'(bus.redir_taken), 64'd1);
    check_val("t6b_rtgt", 64'(bus.redir_target), 64'h1040);
    do_flush();

    // Flush in the same cycle as an acceptance discards the block.
    fill(C_ADDI);
    @(negedge clk);
    drive(39'h3000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd12);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check_val("t7_flush_acc", 64'(bus.out_valid), 64'd0);

    // Backpressure with flush on the second held cycle.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(39'h4000, 8'h0F, 1'b0, 3'd0, 39'h0, 4'd5);
    check_val("t8_valid", 64'(bus.out_valid), 64'd1);
    check_val("t8_num0", 64'(bus.out_num), 64'd4);
    check_val("t8_rdy0", 64'(bus.in_ready), 64'd0);
    drive(39'h4010, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd6);
    @(posedge clk); #1;
    check_val("t8_num1", 64'(bus.out_num), 64'd4);
    check_val("t8_fsq1", 64'(bus.out_fsq_idx), 64'd5);
    check_val("t8_rdy1", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check_val("t8_flushed", 64'(bus.out_valid), 64'd0);
    check_val("t8_rdy2", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;

    // Reset mid-stream loses the carry.
    fill(C_ADDI); put(7, ADD[15:0]);
    send(39'h1000, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check_val("t9_rst_valid", 64'(bus.out_valid), 64'd0);
    fill(C_ADDI); put(0, ADD[31:16]);
    send(39'h1010, 8'hFF, 1'b0, 3'd0, 39'h0, 4'd2);
    check_val("t9_off0", 64'(slot_off(0)), 64'd0);
    check_val("t9_inst0", 64'(slot_inst(0)), 64'h31);
    check_val("t9_num", 64'(bus.out_num), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/predecode_align_stage.md
Name: predecode_align_stage

Overview:
- Parametrised successor to the frontend predecoder, sitting between ICache output and the instruction buffer.
- Splits a fetch block into RVC/RVI instructions and carries a split RVI (with its real low halfword) across blocks.
- Predecodes control flow and checks the BPU prediction; emits compacted instructions plus an early redirect.
- Uses valid/ready handshakes instead of a full flag, and supports RVC-off mode and configurable block width.

Parameters:
FETCH_BYTES, 32, fetch block size in bytes (power of 2, >=8); HW = FETCH_BYTES/2 halfword slots, HW_W = $clog2(HW)
VADDR_SIZE, 39, virtual address width
FSQ_WIDTH, 4, fetch-stream-queue index width
RVC_EN, 1, 1 = compressed ISA enabled; 0 = every instruction 4-byte aligned, odd halfwords ignored

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  fetch block valid
in_ready  out  1  block accepts input this cycle
in_data  in  FETCH_BYTES*8  fetch bytes, halfword i = bits [16i+15:16i]
in_hw_mask  in  HW  valid halfwords, contiguous from bit 0
in_start_addr  in  VADDR_SIZE  address of halfword 0 (2-byte aligned)
in_fsq_idx  in  FSQ_WIDTH  stream index
in_taken  in  1  BPU predicted a taken branch in this block
in_taken_hw  in  HW_W  index of the last halfword of the predicted-taken instruction
in_target  in  VADDR_SIZE  predicted target
flush  in  1  backend/BPU redirect; kills all state
out_valid  out  1  output block valid
out_ready  in  1  ibuffer accepts
out_num  out  HW_W+1  instruction count, packed from slot 0
out_inst  out  HW*32  instructions (RVC in low 16 bits, upper zero)
out_offset  out  HW*(HW_W+1)  halfword offset of each instruction start; carried RVI = HW (meaning -1)
out_rvc  out  HW  per-slot RVC flag
out_fsq_idx  out  FSQ_WIDTH  stream index
redir_valid  out  1  predecode redirect, qualified by out_valid&out_ready
redir_fsq_idx  out  FSQ_WIDTH  stream to repair
redir_taken  out  1  corrected direction
redir_target  out  VADDR_SIZE  corrected next PC
redir_hw  out  HW_W  last halfword of corrected stream end

Behaviour:
- Reset is synchronous and active-high. On reset: out_valid=0, redir_valid=0, carry_valid=0, drop=0, and all data registers =0. in_ready=1 on the cycle after reset.
- Timing: combinational decode of the input, one output register. Latency 1 cycle.
- in_ready = ~out_valid | out_ready. A block is accepted when in_valid & in_ready.
- Boundary detection (RVC_EN=1):
  - Walk halfwords from 0. Slot 0 is a continuation if carry_valid and in_start_addr == carry_pc+2.
  - Continuation: emit {hw0, carry_hw} as out slot 0 with out_offset=HW and out_rvc=0.
  - A halfword whose bits[1:0] != 2'b11 is RVC; otherwise it is RVI and consumes the next halfword.
- Boundary detection (RVC_EN=0): instructions sit at even halfwords only.
- Carry rule: if the last valid halfword starts an RVI and no taken redirect truncates before it, then:
  - store carry_hw, carry_pc, carry_valid=1;
  - exclude that halfword from out_num.
- If carry_valid and the next accepted block's address mismatches, drop the carry silently.
- Predecode per instruction:
  - jal, c.j, c.jal: direct; target = pc + imm.
  - branch, c.beqz, c.bnez: cond.
  - jalr, c.jr, c.jalr: indirect.
- Checks, first match wins:
  1. Earliest direct jump J lies before the predicted end, or in_taken=0. Truncate after J; redir_taken=1, redir_target=J.target, redir_hw=J's last halfword.
  2. in_taken=1 and no instruction ends at in_taken_hw, or the instruction ending there is not control flow. Truncate after in_taken_hw; redir_taken=0, redir_target=in_start_addr+2*(in_taken_hw+1), redir_hw=in_taken_hw.
  3. Predicted instruction is direct and in_target != computed target. Use redir_target=computed target, redir_taken=1.
- A redirect clears any new carry.
- redir_valid is registered alongside the block. Once out_valid&out_ready&redir_valid has occurred, drop=1:
  - later inputs are accepted and discarded;
  - drop clears only on flush.
- Backpressure: out_valid & ~out_ready holds every output stable. The carry updates only on acceptance.
- flush has priority over everything in the same cycle: clears out_valid, redir_valid, carry_valid and drop, and discards any input accepted that cycle.
- Widths: all PC arithmetic is modulo 2^VADDR_SIZE. out_num saturates at HW (cannot overflow).
- Reset mid-stream: identical to the reset state; no partial carry survives.

Decomposition:
- Shared frontend package holds:
  - PdInstInfo struct {rvc, direct, cond, indirect, target};
  - RVC/RVI opcode constants;
  - HW/HW_W derivation functions.
- Sub-module pd_inst_decoder: one 32-bit window plus pc in, PdInstInfo out. Combinational, instantiated HW times.

Test Plan:
- FETCH_BYTES=16, mask=FF, 8 c.addi at 0x1000, in_taken=0 -> out_num=8, offsets 0..7, no redirect.
- Block at 0x1000 with RVI low half in hw7, then block at 0x1010 with its high half -> first block out_num=7; second block slot0 = {hw0,hw7_prev}, offset=8 (i.e. -1), carry_valid=0.
- Carry held, next block address 0x2000 -> carry dropped, slot0 decoded normally.
- c.j at hw2 (target 0x1040), in_taken=0 -> out_num=3, redir_taken=1, target 0x1040, hw=2; following inputs discarded until flush.
- in_taken=1, in_taken_hw=5 on an add -> redir_taken=0, target 0x100C, out_num=6.
- out_ready=0 for 3 cycles with a pending block -> outputs stable, in_ready=0; flush on cycle 2 -> out_valid=0 next cycle.
